// File: rtl/dilithium_pkg.sv
// Shared ML-DSA constants, challenge coefficient encoding, nonzero-list entry and
// sparse-multiplier FSM state type.
package dilithium_pkg;
  localparam int          DIL_N  = 256;
  localparam logic [23:0] DIL_Q  = 24'd8380417;
  localparam int          TAUMAX = 60;

  localparam logic [1:0] C_ZERO = 2'b00;
  localparam logic [1:0] C_POS  = 2'b01;
  localparam logic [1:0] C_NEG  = 2'b11;

  typedef enum logic [2:0] {ST_IDLE, ST_SCAN, ST_MAC, ST_WR, ST_FIN} csm_state_t;

  typedef struct packed {
    logic [7:0] pos;
    logic       neg;
  } nz_entry_t;

  function automatic logic [7:0] tau_of_level(input logic [1:0] level);
    case (level)
      2'b00:   return 8'd39;
      2'b01:   return 8'd49;
      default: return 8'd60;
    endcase
  endfunction
endpackage

// File: rtl/csm_modq_addsub.sv
// Combinational modular add/subtract: result = (acc +/- s) mod Q for acc, s in [0,Q).
module csm_modq_addsub
  import dilithium_pkg::*;
#(
  parameter int DATA_W = 24
) (
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] s,
  input  logic              sub,
  output logic [DATA_W-1:0] result
);
  localparam logic signed [DATA_W:0] QX = (DATA_W+1)'(DIL_Q);

  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] t;
    t = $signed({1'b0, a}) + $signed({1'b0, b});
    if (t >= QX) t = t - QX;
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] t;
    t = $signed({1'b0, a}) - $signed({1'b0, b});
    if (t < 0) t = t + QX;
    return t[DATA_W-1:0];
  endfunction

  assign result = sub ? mod_sub(acc, s) : mod_add(acc, s);
endmodule

// File: rtl/challenge_sparse_mul.sv
// Sparse challenge multiplier: scans c, compacts its nonzeros, then writes w = c*s mod (X^256+1, Q).
// Defining CSMUL_PERF_CNT_EN adds the perf_cycles busy-cycle counter port.
module challenge_sparse_mul
  import dilithium_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  ml_dsa_level,
  input  logic [15:0] c_base,
  input  logic [15:0] s_base,
  input  logic [15:0] w_base,
  output logic        busy,
  output logic        done,
  output logic        err_weight,
  output logic [15:0] mem_A,
  output logic [23:0] mem_D,
  output logic        mem_WEB,
  input  logic [23:0] mem_Q
`ifdef CSMUL_PERF_CNT_EN
  ,
  output logic [15:0] perf_cycles
`endif
);
  localparam logic [7:0] TAUMAX8 = 8'(TAUMAX);

  csm_state_t  state;
  logic [8:0]  cnt;
  logic [7:0]  k;
  logic [7:0]  nz_cnt;
  logic [7:0]  tau_r;
  logic [15:0] c_base_r, s_base_r, w_base_r;
  nz_entry_t   list [TAUMAX];
  logic [23:0] acc;

  logic        coef_nz, coef_neg, scan_hit;
  logic [7:0]  scan_pos, nz_upd, first_pos;
  logic [5:0]  list_len, rd_idx, nxt_idx;
  logic        mac_sub;
  logic [23:0] sum_res, wr_data;

  function automatic logic [15:0] s_addr(input logic [15:0] base, input logic [7:0] kk, input logic [7:0] p);
    logic [7:0] d;
    d = kk - p;
    return base + {8'h00, d};
  endfunction

  always_comb begin
    coef_nz  = 1'b0;
    coef_neg = 1'b0;
    case (mem_Q[1:0])
      C_POS:   coef_nz = 1'b1;
      C_NEG:   begin coef_nz = 1'b1; coef_neg = 1'b1; end
      C_ZERO:  coef_nz = 1'b0;
      default: coef_nz = 1'b0;
    endcase
  end

  // During SCAN the response in cycle cnt belongs to coefficient cnt-1.
  assign scan_pos  = 8'(cnt - 9'd1);
  assign scan_hit  = (state == ST_SCAN) && (cnt != 9'd0) && coef_nz;
  assign nz_upd    = scan_hit ? ((nz_cnt == 8'hFF) ? nz_cnt : nz_cnt + 8'd1) : nz_cnt;
  assign list_len  = (nz_cnt > TAUMAX8) ? TAUMAX8[5:0] : nz_cnt[5:0];
  // Entry 0 may still be in flight on the last SCAN cycle, so bypass it.
  assign first_pos = (nz_cnt == 8'd0) ? scan_pos : list[0].pos;

  assign rd_idx  = 6'(cnt - 9'd1);
  assign nxt_idx = 6'(cnt + 9'd1);
  assign mac_sub = list[rd_idx].neg ^ (k < list[rd_idx].pos);
  assign wr_data = (cnt != 9'd0) ? sum_res : acc;

  csm_modq_addsub #(.DATA_W(24)) u_addsub (
    .acc    (acc),
    .s      (mem_Q),
    .sub    (mac_sub),
    .result (sum_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_weight <= 1'b0;
      mem_A      <= '0;
      mem_D      <= '0;
      mem_WEB    <= 1'b1;
      nz_cnt     <= '0;
      cnt        <= '0;
      k          <= '0;
      tau_r      <= '0;
      c_base_r   <= '0;
      s_base_r   <= '0;
      w_base_r   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start) begin
          state      <= ST_SCAN;
          busy       <= 1'b1;
          err_weight <= 1'b0;
          nz_cnt     <= '0;
          cnt        <= '0;
          k          <= '0;
          tau_r      <= tau_of_level(ml_dsa_level);
          c_base_r   <= c_base;
          s_base_r   <= s_base;
          w_base_r   <= w_base;
          mem_A      <= c_base;
        end
        ST_SCAN: begin
          nz_cnt <= nz_upd;
          cnt    <= cnt + 9'd1;
          if (cnt < 9'(DIL_N - 1)) mem_A <= c_base_r + 16'(cnt) + 16'd1;
          if (cnt == 9'(DIL_N)) begin
            state      <= ST_MAC;
            cnt        <= '0;
            k          <= '0;
            err_weight <= (nz_upd != tau_r);
            mem_A      <= s_addr(s_base_r, 8'd0, first_pos);
          end
        end
        // MAC: address for entry cnt is on the bus, response for entry cnt-1 arrives.
        ST_MAC: begin
          cnt <= cnt + 9'd1;
          if (cnt + 9'd1 < {3'b000, list_len}) mem_A <= s_addr(s_base_r, k, list[nxt_idx].pos);
          if (cnt == {3'b000, list_len}) begin
            state   <= ST_WR;
            mem_A   <= w_base_r + {8'h00, k};
            mem_D   <= wr_data;
            mem_WEB <= 1'b0;
          end
        end
        ST_WR: begin
          mem_WEB <= 1'b1;
          cnt     <= '0;
          if (k == 8'hFF) begin
            state <= ST_FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            k     <= k + 8'd1;
            state <= ST_MAC;
            mem_A <= s_addr(s_base_r, k + 8'd1, first_pos);
          end
        end
        ST_FIN: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (scan_hit && (nz_cnt < TAUMAX8)) list[nz_cnt[5:0]] <= {scan_pos, coef_neg};
    if (state == ST_MAC) begin
      if (cnt != 9'd0) acc <= sum_res;
    end else begin
      acc <= '0;
    end
  end

`ifdef CSMUL_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         perf_cycles <= '0;
    else if (state == ST_IDLE && start) perf_cycles <= '0;
    else if (busy)                      perf_cycles <= perf_cycles + 16'd1;
  end
`endif
endmodule
